// File: rtl/psum_row_sequencer.sv
// Partial-sum row sequencer: collects ROWS_P psum packets, accumulates them, emits one routed result.
// Optional macro PSUM_SAT_EN: saturating accumulate with a clamp flag in the result type bit.
module psum_row_sequencer #(
    parameter int unsigned ROWS_P  = 5,
    parameter int unsigned PSUM_W  = 13,
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned PKT_W   = 57,
    parameter int unsigned NODE_ID = 13,
    parameter int unsigned SINK_ID = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt,
    output logic             busy,
    output logic             err_misroute
);
    localparam int unsigned CNT_W    = $clog2(ROWS_P + 1);
    localparam int unsigned IDX_W    = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
    localparam int unsigned ADDR_LSB = PSUM_W;
    localparam int unsigned DEST_LSB = PSUM_W + ADDR_W + 8;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    localparam logic [3:0] NODE_A = 4'(NODE_ID);
    localparam logic [3:0] SINK_A = 4'(SINK_ID);
    localparam logic [2:0] X_HOP  = 3'(SINK_ID - NODE_ID);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  row_cnt, row_cnt_d;
    logic [CNT_W-1:0]  rd_ptr;
    logic [PSUM_W-1:0] acc, acc_next;
    logic [ADDR_W-1:0] last_addr;
    logic [PSUM_W-1:0] row_buf [ROWS_P];

    logic take_hit, take_miss, row_done, acc_step, emit_load, out_done;
    logic in_ready_d, busy_d;
    logic pkt_type;

    wire [3:0]        in_dest = in_pkt[DEST_LSB +: 4];
    wire [ADDR_W-1:0] in_addr = in_pkt[ADDR_LSB +: ADDR_W];
    wire [PSUM_W-1:0] in_data = in_pkt[PSUM_W-1:0];
    wire [PSUM_W-1:0] rd_data = row_buf[IDX_W'(rd_ptr)];

`ifdef PSUM_SAT_EN
    logic              sat_q;
    logic [PSUM_W:0]   acc_sum;
    assign acc_sum  = {1'b0, acc} + {1'b0, rd_data};
    assign acc_next = acc_sum[PSUM_W] ? {PSUM_W{1'b1}} : acc_sum[PSUM_W-1:0];
    assign pkt_type = sat_q;

    // Sticky per-row clamp indicator, cleared when a new accumulate pass starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (row_done) begin
            sat_q <= 1'b0;
        end else if (acc_step && acc_sum[PSUM_W]) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign acc_next = acc + rd_data;
    assign pkt_type = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; ACCUM spends one extra cycle to register the result
    always_comb begin
        state_d   = state_q;
        take_hit  = 1'b0;
        take_miss = 1'b0;
        row_done  = 1'b0;
        acc_step  = 1'b0;
        emit_load = 1'b0;
        out_done  = 1'b0;
        row_cnt_d = row_cnt;
        case (state_q)
            S_COLLECT: begin
                if (in_valid && in_ready) begin
                    if (in_dest == NODE_A) begin
                        take_hit = 1'b1;
                        if (row_cnt == CNT_W'(ROWS_P - 1)) begin
                            row_done  = 1'b1;
                            row_cnt_d = '0;
                            state_d   = S_ACCUM;
                        end else begin
                            row_cnt_d = row_cnt + CNT_W'(1);
                        end
                    end else begin
                        take_miss = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (rd_ptr == CNT_W'(ROWS_P)) begin
                    emit_load = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    acc_step = 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_done = 1'b1;
                    state_d  = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
        in_ready_d = (state_d == S_COLLECT);
        busy_d     = !((state_d == S_COLLECT) && (row_cnt_d == '0));
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt      <= '0;
            rd_ptr       <= '0;
            acc          <= '0;
            last_addr    <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_pkt      <= '0;
            err_misroute <= 1'b0;
        end else begin
            row_cnt  <= row_cnt_d;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            if (take_hit) begin
                last_addr <= in_addr;
            end
            if (take_miss) begin
                err_misroute <= 1'b1;
            end
            if (row_done) begin
                acc    <= '0;
                rd_ptr <= '0;
            end else if (acc_step) begin
                acc    <= acc_next;
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            if (emit_load) begin
                out_valid <= 1'b1;
                out_pkt   <= PKT_W'({pkt_type, NODE_A, SINK_A, 1'b1, X_HOP,
                                     1'b1, 3'b000, last_addr, acc});
            end else if (out_done) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Row buffer contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (take_hit) begin
            row_buf[IDX_W'(row_cnt)] <= in_data;
        end
    end

endmodule

// File: tb/tb_psum_row_sequencer.sv
// Scoreboard bench for psum_row_sequencer: NODE_ID=13 instance (dut_a) and NODE_ID=14 instance (dut_b).
module tb_psum_row_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy, a_err;
    logic [56:0] a_in_pkt = '0, a_out_pkt;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy, b_err;
    logic [56:0] b_in_pkt = '0, b_out_pkt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [56:0] qa[$];
    logic [56:0] qb[$];

    always #5 clk = ~clk;

    psum_row_sequencer #(.NODE_ID(13)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pkt(a_in_pkt),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pkt(a_out_pkt),
        .busy(a_busy), .err_misroute(a_err)
    );

    psum_row_sequencer #(.NODE_ID(14)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pkt(b_in_pkt),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pkt(b_out_pkt),
        .busy(b_busy), .err_misroute(b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [56:0] mk_pkt(input logic [3:0] dest, input logic [12:0] data,
                                           input logic [26:0] addr);
        return {1'b0, 4'h3, dest, 1'b0, 3'd0, 1'b0, 3'd0, addr, data};
    endfunction

    function automatic logic [56:0] exp_pkt(input logic typ, input logic [3:0] src,
                                            input logic [2:0] xhop, input logic [26:0] addr,
                                            input logic [12:0] data);
        return {typ, src, 4'd15, 1'b1, xhop, 1'b1, 3'd0, addr, data};
    endfunction

    // Drive one packet to the selected DUT; returns the cycles spent waiting for in_ready
    task automatic send(input bit sel, input logic [3:0] dest, input logic [12:0] data,
                        input logic [26:0] addr, output int waits);
        waits = 0;
        if (sel) begin b_in_pkt = mk_pkt(dest, data, addr); b_in_valid = 1'b1; end
        else     begin a_in_pkt = mk_pkt(dest, data, addr); a_in_valid = 1'b1; end
        while (!(sel ? b_in_ready : a_in_ready) && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 50) check("send_timeout", 64'(waits), 64'(0));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic send_row(input bit sel, input logic [3:0] dest, input logic [12:0] d0,
                            input logic [12:0] d1, input logic [12:0] d2, input logic [12:0] d3,
                            input logic [12:0] d4, input logic [26:0] last_addr);
        int w;
        send(sel, dest, d0, 27'h11, w);
        send(sel, dest, d1, 27'h22, w);
        send(sel, dest, d2, 27'h33, w);
        send(sel, dest, d3, 27'h44, w);
        send(sel, dest, d4, last_addr, w);
    endtask

    task automatic drain(input bit sel);
        int n = 0;
        while (((sel ? qb.size() : qa.size()) != 0 || (sel ? b_busy : a_busy)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(sel ? "drain_b" : "drain_a", 64'(n < 100), 64'(1));
    endtask

    // Output monitors: compare on every presented transfer
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_unexpected_out", 64'(a_out_pkt), 64'(0));
            else check("a_out_pkt", 64'(a_out_pkt), 64'(qa.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("b_unexpected_out", 64'(b_out_pkt), 64'(0));
            else check("b_out_pkt", 64'(b_out_pkt), 64'(qb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        logic [56:0] snap;

        // Reset values
        #3;
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_pkt", 64'(a_out_pkt), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_err", 64'(a_err), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'(1));

        // T1: reset in the middle of ACCUM aborts the row
        send_row(1'b0, 4'd13, 13'd99, 13'd99, 13'd99, 13'd99, 13'd99, 27'h777);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1_busy_accum", 64'(a_busy), 64'(1));
        rst_n = 1'b0;
        #2;
        check("t1_rst_out_valid", 64'(a_out_valid), 64'(0));
        check("t1_rst_busy", 64'(a_busy), 64'(0));
        check("t1_rst_in_ready", 64'(a_in_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t1_in_ready", 64'(a_in_ready), 64'(1));
        check("t1_busy", 64'(a_busy), 64'(0));
        check("t1_out_valid", 64'(a_out_valid), 64'(0));
        qa.push_back(exp_pkt(1'b0, 4'd13, 3'd2, 27'h42, 13'd6));
        send_row(1'b0, 4'd13, 13'd1, 13'd1, 13'd1, 13'd1, 13'd2, 27'h42);
        drain(1'b0);

        // T2: basic row and output latency
        qa.push_back(exp_pkt(1'b0, 4'd13, 3'd2, 27'h123, 13'd15));
        send_row(1'b0, 4'd13, 13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 27'h123);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) check("t2_accum_in_ready", 64'(a_in_ready), 64'(0));
            if (a_out_valid) break;
        end
        check("t2_latency", 64'(n), 64'(6));
        drain(1'b0);

        // T3: backpressure holds the result stable
        a_out_ready = 1'b0;
        qa.push_back(exp_pkt(1'b0, 4'd13, 3'd2, 27'h55, 13'd150));
        send_row(1'b0, 4'd13, 13'd10, 13'd20, 13'd30, 13'd40, 13'd50, 27'h55);
        n = 0;
        while (!a_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("t3_valid_seen", 64'(a_out_valid), 64'(1));
        snap = a_out_pkt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t3_pkt_stable", 64'(a_out_pkt), 64'(snap));
            check("t3_hold_in_ready", 64'({a_out_valid, a_in_ready}), 64'(2'b10));
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_transfer", 64'(a_out_valid), 64'(0));
        drain(1'b0);

        // T4: misrouted packet dropped and flagged
        qa.push_back(exp_pkt(1'b0, 4'd13, 3'd2, 27'h3AB, 13'd45));
        send(1'b0, 4'd13, 13'd7, 27'h1, w);
        send(1'b0, 4'd13, 13'd8, 27'h2, w);
        send(1'b0, 4'd7, 13'd100, 27'h666, w);
        check("t4_err", 64'(a_err), 64'(1));
        send(1'b0, 4'd13, 13'd9, 27'h3, w);
        send(1'b0, 4'd13, 13'd10, 27'h4, w);
        send(1'b0, 4'd13, 13'd11, 27'h3AB, w);
        drain(1'b0);

        // T5: overflow
`ifdef PSUM_SAT_EN
        qa.push_back(exp_pkt(1'b1, 4'd13, 3'd2, 27'h7FF, 13'd8191));
`else
        qa.push_back(exp_pkt(1'b0, 4'd13, 3'd2, 27'h7FF, 13'd3808));
`endif
        send_row(1'b0, 4'd13, 13'd4000, 13'd4000, 13'd4000, 13'd0, 13'd0, 27'h7FF);
        drain(1'b0);
        check("t5_err_sticky", 64'(a_err), 64'(1));

        // T6: NODE_ID=14 instance, back-to-back rows
        qb.push_back(exp_pkt(1'b0, 4'd14, 3'd1, 27'h9, 13'd50));
        send_row(1'b1, 4'd14, 13'd10, 13'd10, 13'd10, 13'd10, 13'd10, 27'h9);
        n = 0;
        while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("t6_valid_seen", 64'(b_out_valid), 64'(1));
        @(posedge clk); #1;
        check("t6_transfer", 64'(b_out_valid), 64'(0));
        check("t6_in_ready_next", 64'(b_in_ready), 64'(1));
        qb.push_back(exp_pkt(1'b0, 4'd14, 3'd1, 27'h200, 13'd15));
        send(1'b1, 4'd14, 13'd1, 27'h1, w);
        check("t6_first_accept_wait", 64'(w), 64'(0));
        send(1'b1, 4'd14, 13'd2, 27'h2, w);
        send(1'b1, 4'd14, 13'd3, 27'h3, w);
        send(1'b1, 4'd14, 13'd4, 27'h4, w);
        send(1'b1, 4'd14, 13'd5, 27'h200, w);
        drain(1'b1);
        check("t6_err_b", 64'(b_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
